// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Tracks the destination registers of the instructions in EX, MEM and WB and
// derives two things for the instruction sitting in ID:
//   * registered operand-forwarding selects used once that instruction is in EX
//   * a combinational load-use stall request toward PC / IF-ID
// Integer and FP register files are distinguished by a one-bit file tag; x0 is
// never a forwarding source while f0 is an ordinary register.
module hazard_forward_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rs1_fp,
  input  logic        id_rs2_fp,
  input  logic        id_rd_fp,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        hold,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic [15:0] load_use_count
);

  // Operand mux select encodings (3 is never produced).
  localparam logic [1:0]  SEL_RF  = 2'd0;
  localparam logic [1:0]  SEL_MEM = 2'd1;
  localparam logic [1:0]  SEL_EX  = 2'd2;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // True when a tracked producer slot will write the register the source names.
  // The integer zero register is hard-wired and can never be forwarded.
  function automatic logic src_match(
    input logic [4:0] src,
    input logic       src_fp,
    input logic       slot_vld,
    input logic       slot_we,
    input logic [4:0] slot_rd,
    input logic       slot_rd_fp
  );
    logic is_x0;
    is_x0     = (src_fp == 1'b0) && (src == 5'd0);
    src_match = slot_vld && slot_we && (slot_rd == src) &&
                (slot_rd_fp == src_fp) && !is_x0;
  endfunction

  // Newest producer wins: the EX result is younger than the MEM result.
  function automatic logic [1:0] fwd_sel(
    input logic hit_ex,
    input logic hit_mem
  );
    if (hit_ex)
      fwd_sel = SEL_EX;
    else if (hit_mem)
      fwd_sel = SEL_MEM;
    else
      fwd_sel = SEL_RF;
  endfunction

  // Saturating increment for the stall statistics counter.
  function automatic logic [15:0] sat_inc(
    input logic [15:0] value
  );
    if (value == COUNT_MAX)
      sat_inc = value;
    else
      sat_inc = value + 16'd1;
  endfunction

  // EX slot (_p0)
  logic       vld_p0;
  logic [4:0] rd_p0;
  logic       rd_fp_p0;
  logic       we_p0;
  logic       mr_p0;

  // MEM slot (_p1)
  logic       vld_p1;
  logic [4:0] rd_p1;
  logic       rd_fp_p1;
  logic       we_p1;
  logic       mr_p1;

  // WB slot (_p2)
  logic       vld_p2;
  logic [4:0] rd_p2;
  logic       rd_fp_p2;
  logic       we_p2;

  // Forward selects for the instruction now in EX, and the stall counter.
  logic [1:0]  fwd_a_p0;
  logic [1:0]  fwd_b_p0;
  logic [15:0] lu_count;

  // ID-stage hazard detection (combinational)
  logic rs1_hit_ex;
  logic rs1_hit_mem;
  logic rs2_hit_ex;
  logic rs2_hit_mem;
  logic load_use;
  logic squash;

  assign rs1_hit_ex  = src_match(id_rs1, id_rs1_fp, vld_p0, we_p0, rd_p0, rd_fp_p0);
  assign rs1_hit_mem = src_match(id_rs1, id_rs1_fp, vld_p1, we_p1, rd_p1, rd_fp_p1);
  assign rs2_hit_ex  = src_match(id_rs2, id_rs2_fp, vld_p0, we_p0, rd_p0, rd_fp_p0);
  assign rs2_hit_mem = src_match(id_rs2, id_rs2_fp, vld_p1, we_p1, rd_p1, rd_fp_p1);

  // A load in EX cannot supply its data until it reaches MEM, so a dependent
  // instruction in ID must wait one cycle. Freeze, squash and reset all win.
  assign load_use = id_valid && mr_p0 && (rs1_hit_ex || rs2_hit_ex);
  assign stall    = load_use && !flush && !hold && !reset;

  // Either a squash or a stall drops a bubble into EX.
  assign squash = flush || stall;

  // WB contents are kept for completeness of the tracked pipeline image but do
  // not feed a select; the MEM load flag likewise has no later consumer.
  logic unused_wb;
  assign unused_wb = ^{vld_p2, rd_p2, rd_fp_p2, we_p2, mr_p1};

  // Advance the producer-tracking slots EX -> MEM -> WB, inserting bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      rd_p0    <= 5'd0;
      rd_fp_p0 <= 1'b0;
      we_p0    <= 1'b0;
      mr_p0    <= 1'b0;
      vld_p1   <= 1'b0;
      rd_p1    <= 5'd0;
      rd_fp_p1 <= 1'b0;
      we_p1    <= 1'b0;
      mr_p1    <= 1'b0;
      vld_p2   <= 1'b0;
      rd_p2    <= 5'd0;
      rd_fp_p2 <= 1'b0;
      we_p2    <= 1'b0;
    end else if (!hold) begin
      // MEM -> WB
      vld_p2   <= vld_p1;
      rd_p2    <= rd_p1;
      rd_fp_p2 <= rd_fp_p1;
      we_p2    <= we_p1;
      // EX -> MEM
      vld_p1   <= vld_p0;
      rd_p1    <= rd_p0;
      rd_fp_p1 <= rd_fp_p0;
      we_p1    <= we_p0;
      mr_p1    <= mr_p0;
      // ID -> EX
      if (squash) begin
        vld_p0   <= 1'b0;
        rd_p0    <= 5'd0;
        rd_fp_p0 <= 1'b0;
        we_p0    <= 1'b0;
        mr_p0    <= 1'b0;
      end else begin
        vld_p0   <= id_valid;
        rd_p0    <= id_rd;
        rd_fp_p0 <= id_rd_fp;
        we_p0    <= id_reg_write && id_valid;
        mr_p0    <= id_mem_read && id_valid;
      end
    end
  end

  // Register the forward selects so they are ready the cycle the ID
  // instruction lands in EX; a bubble entering EX gets register-file selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_p0 <= SEL_RF;
      fwd_b_p0 <= SEL_RF;
    end else if (!hold) begin
      if (squash) begin
        fwd_a_p0 <= SEL_RF;
        fwd_b_p0 <= SEL_RF;
      end else begin
        fwd_a_p0 <= fwd_sel(rs1_hit_ex, rs1_hit_mem);
        fwd_b_p0 <= fwd_sel(rs2_hit_ex, rs2_hit_mem);
      end
    end
  end

  // Count cycles lost to load-use stalls, pinned at full scale.
  always_ff @(posedge clk) begin
    if (reset)
      lu_count <= 16'd0;
    else if (stall)
      lu_count <= sat_inc(lu_count);
  end

  assign forward_a      = fwd_a_p0;
  assign forward_b      = fwd_b_p0;
  assign load_use_count = lu_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: hand-computed forwarding selects,
// stall requests and stall counts for short instruction sequences.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_rs1_fp;
  logic        id_rs2_fp;
  logic        id_rd_fp;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        hold;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic [15:0] load_use_count;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_count;

  hazard_forward_unit dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_rs1_fp      (id_rs1_fp),
    .id_rs2_fp      (id_rs2_fp),
    .id_rd_fp       (id_rd_fp),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .flush          (flush),
    .hold           (hold),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .stall          (stall),
    .load_use_count (load_use_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction in ID.
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic rs1f,
                        input logic [4:0] rs2, input logic rs2f,
                        input logic [4:0] rd, input logic rdf,
                        input logic we, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_fp = rs1f; id_rs2 = rs2; id_rs2_fp = rs2f;
    id_rd = rd; id_rd_fp = rdf; id_reg_write = we; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    nop();
    repeat (2) step();
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b: got %0d expected 0", forward_b); end
    vectors++; if (load_use_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", load_use_count); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    reset = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_ex_forward();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0); #1;     // add x6,x5,x0
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall: got %0b expected 0", stall); end
    step();
    vectors++; if (forward_a !== 2'd2) begin errors++; $display("FAIL ex_fwd_a: got %0d expected 2", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL ex_fwd_b: got %0d expected 0", forward_b); end
    drain();
  endtask

  task automatic test_mem_forward();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0); step(); // add x9
    set_id(1'b1, 5'd2, 1'b0, 5'd5, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0); step(); // rs2=x5
    vectors++; if (forward_b !== 2'd1) begin errors++; $display("FAIL mem_fwd_b: got %0d expected 1", forward_b); end
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL mem_fwd_a: got %0d expected 0", forward_a); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd3, 1'b0, 5'd4, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5 again
    set_id(1'b1, 5'd2, 1'b0, 5'd5, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0); step();
    vectors++; if (forward_b !== 2'd2) begin errors++; $display("FAIL newest_fwd_b: got %0d expected 2", forward_b); end
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL newest_fwd_a: got %0d expected 0", forward_a); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0); step(); // add x6
    set_id(1'b1, 5'd5, 1'b0, 5'd6, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0); step();
    vectors++; if (forward_a !== 2'd1) begin errors++; $display("FAIL split_fwd_a: got %0d expected 1", forward_a); end
    vectors++; if (forward_b !== 2'd2) begin errors++; $display("FAIL split_fwd_b: got %0d expected 2", forward_b); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1); step(); // lw x7
    set_id(1'b1, 5'd7, 1'b0, 5'd3, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %0b expected 1", stall); end
    step();
    exp_count = 16'd1;
    vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL lu_count: got %0d expected %0d", load_use_count, exp_count); end
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %0b expected 0", stall); end
    step();
    vectors++; if (forward_a !== 2'd1) begin errors++; $display("FAIL lu_fwd_a: got %0d expected 1", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL lu_fwd_b: got %0d expected 0", forward_b); end
    vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL lu_count_once: got %0d expected %0d", load_use_count, exp_count); end
    drain();
  endtask

  task automatic test_x0_fp();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step(); // write x0
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0); step();
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL x0_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL x0_fwd_b: got %0d expected 0", forward_b); end
    drain();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0); step(); // write f0
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0); step();
    vectors++; if (forward_a !== 2'd2) begin errors++; $display("FAIL f0_fwd_a: got %0d expected 2", forward_a); end
    vectors++; if (forward_b !== 2'd2) begin errors++; $display("FAIL f0_fwd_b: got %0d expected 2", forward_b); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0); step(); // write x3
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0); step(); // f3, x3
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL fp_file_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd2) begin errors++; $display("FAIL int_file_fwd_b: got %0d expected 2", forward_b); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step(); // lw x0
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_lu_stall: got %0b expected 0", stall); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0); flush = 1'b1; step(); flush = 1'b0;
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL flush_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL flush_fwd_b: got %0d expected 0", forward_b); end
    set_id(1'b1, 5'd6, 1'b0, 5'd5, 1'b0, 5'd11, 1'b0, 1'b1, 1'b0); step();
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL flush_bubble_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd1) begin errors++; $display("FAIL flush_bubble_b: got %0d expected 1", forward_b); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1); step(); // lw x7
    set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); flush = 1'b1; #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_masks_stall: got %0b expected 0", stall); end
    step(); flush = 1'b0;
    vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL flush_count: got %0d expected %0d", load_use_count, exp_count); end
    drain();
  endtask

  task automatic test_hold();
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0); step(); // add x5
    set_id(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1); step(); // lw x7,(x5)
    vectors++; if (forward_a !== 2'd2) begin errors++; $display("FAIL hold_pre_fwd_a: got %0d expected 2", forward_a); end
    set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); hold = 1'b1; #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_masks_stall: got %0b expected 0", stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (forward_a !== 2'd2) begin errors++; $display("FAIL hold_fwd_a[%0d]: got %0d expected 2", i, forward_a); end
      vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL hold_fwd_b[%0d]: got %0d expected 0", i, forward_b); end
      vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL hold_count[%0d]: got %0d expected %0d", i, load_use_count, exp_count); end
      vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d]: got %0b expected 0", i, stall); end
    end
    hold = 1'b0; #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL resume_stall: got %0b expected 1", stall); end
    step();
    exp_count = exp_count + 16'd1;
    vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL resume_count: got %0d expected %0d", load_use_count, exp_count); end
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL resume_bubble_a: got %0d expected 0", forward_a); end
    step();
    vectors++; if (forward_a !== 2'd1) begin errors++; $display("FAIL resume_fwd_a: got %0d expected 1", forward_a); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL resume_stall_off: got %0b expected 0", stall); end
    drain();
  endtask

  task automatic test_saturation();
    force dut.lu_count = 16'hFFFD;
    #1 release dut.lu_count;
    exp_count = 16'hFFFD;
    vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL sat_preset: got %0h expected %0h", load_use_count, exp_count); end
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1); step(); // lw x7
      set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); step(); // stall cycle
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      vectors++; if (load_use_count !== exp_count) begin errors++; $display("FAIL sat_count[%0d]: got %0h expected %0h", i, load_use_count, exp_count); end
      step();
    end
    vectors++; if (load_use_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %0h expected ffff", load_use_count); end
    drain();
    set_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1); step(); // lw x7
    set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0); #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %0b expected 1", stall); end
    reset = 1'b1; #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_masks_stall: got %0b expected 0", stall); end
    step();
    vectors++; if (load_use_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0h expected 0", load_use_count); end
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL rst_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (forward_b !== 2'd0) begin errors++; $display("FAIL rst_fwd_b: got %0d expected 0", forward_b); end
    reset = 1'b0; #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0b expected 0", stall); end
    step();
    vectors++; if (forward_a !== 2'd0) begin errors++; $display("FAIL post_reset_fwd_a: got %0d expected 0", forward_a); end
    vectors++; if (load_use_count !== 16'd0) begin errors++; $display("FAIL post_reset_count: got %0h expected 0", load_use_count); end
    drain();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    nop();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_x0_fp();
    test_flush();
    test_hold();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
